// File: rtl/synaptic_ctrl_pkg.sv
// Shared types and address-mapping helpers for the synaptic update controller.
// One synaptic word holds POST_NEUR_PARALLEL post neurons; word address = pre*POST_WORDS + w.
package synaptic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } syn_state_e;

  localparam int DEF_INPUT_NEURON       = 784;
  localparam int DEF_OUTPUT_NEURON      = 256;
  localparam int DEF_POST_NEUR_PARALLEL = 4;

  function automatic int post_words(input int output_neuron, input int parallel);
    return output_neuron / parallel;
  endfunction

  // Post-neuron base address of the last word in a row.
  function automatic int last_post_base(input int output_neuron, input int parallel);
    return (post_words(output_neuron, parallel) - 1) * parallel;
  endfunction

  localparam int DEF_POST_WORDS = post_words(DEF_OUTPUT_NEURON, DEF_POST_NEUR_PARALLEL);

endpackage

// File: rtl/synaptic_addr_gen.sv
// Nested pre/word counters for the synaptic sweep. The word address and post-neuron
// base are kept as running registers so no multiplier is needed.
module synaptic_addr_gen
  import synaptic_ctrl_pkg::*;
#(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            advance,
  output logic                            last,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_addr,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] post_addr,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] word_addr
);

  localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] LAST_PRE =
    PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] LAST_POST =
    POST_NEUR_ADDR_WIDTH'(last_post_base(OUTPUT_NEURON, POST_NEUR_PARALLEL));
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP =
    POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);

  logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_q, pre_d;
  logic [POST_NEUR_ADDR_WIDTH-1:0] post_q, post_d;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] word_q, word_d;
  logic                            row_end;

  assign row_end = (post_q == LAST_POST);
  assign last    = row_end && (pre_q == LAST_PRE);

  always_comb begin
    pre_d  = pre_q;
    post_d = post_q;
    word_d = word_q;
    if (clear) begin
      pre_d  = '0;
      post_d = '0;
      word_d = '0;
    end else if (advance) begin
      // After the final word everything wraps to zero, ready for the next sweep.
      word_d = last ? '0 : word_q + 1'b1;
      if (row_end) begin
        post_d = '0;
        pre_d  = last ? '0 : pre_q + 1'b1;
      end else begin
        post_d = post_q + POST_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      post_q <= '0;
      word_q <= '0;
    end else begin
      pre_q  <= pre_d;
      post_q <= post_d;
      word_q <= word_d;
    end
  end

  assign pre_addr  = pre_q;
  assign post_addr = post_q;
  assign word_addr = word_q;

endmodule

// File: rtl/synaptic_update_ctrl.sv
// Sweeps every synaptic/gradient word once per training pass: read, then write back
// with an update-commit strobe. Strobes decode only registered state.
module synaptic_update_ctrl
  import synaptic_ctrl_pkg::*;
#(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic                            HOLD,
  input  logic                            IS_TRAIN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            CTRL_SYNARRAY_CS,
  output logic                            CTRL_SYNARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
  output logic                            CTRL_GRAD_ARRAY_CS,
  output logic                            CTRL_GRAD_ARRAY_WE,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEURON_ADDRESS,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_TREF_EVENT
);

  syn_state_e state_q, state_d;
  logic       stall_q, stall_d;
  logic       clear;
  logic       advance;
  logic       last;

  synaptic_addr_gen #(
    .INPUT_NEURON        (INPUT_NEURON),
    .OUTPUT_NEURON       (OUTPUT_NEURON),
    .POST_NEUR_PARALLEL  (POST_NEUR_PARALLEL),
    .PRE_NEUR_ADDR_WIDTH (PRE_NEUR_ADDR_WIDTH),
    .POST_NEUR_ADDR_WIDTH(POST_NEUR_ADDR_WIDTH),
    .SYN_ARRAY_ADDR_WIDTH(SYN_ARRAY_ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear    (clear),
    .advance  (advance),
    .last     (last),
    .pre_addr (CTRL_PRE_NEURON_ADDRESS),
    .post_addr(CTRL_POST_NEURON_ADDRESS),
    .word_addr(CTRL_SYNARRAY_ADDR)
  );

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && IS_TRAIN) begin
          clear   = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        // ABORT wins over HOLD; a held RD keeps its address with chip selects dropped.
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (HOLD) begin
          stall_d = 1'b1;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        advance = 1'b1;
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign BUSY               = (state_q != ST_IDLE);
  assign DONE               = (state_q == ST_FIN);
  assign CTRL_SYNARRAY_CS   = ((state_q == ST_RD) && !stall_q) || (state_q == ST_WR);
  assign CTRL_GRAD_ARRAY_CS = CTRL_SYNARRAY_CS;
  assign CTRL_SYNARRAY_WE   = (state_q == ST_WR);
  assign CTRL_GRAD_ARRAY_WE = (state_q == ST_WR);
  assign CTRL_TREF_EVENT    = (state_q == ST_WR);

endmodule

// File: tb/tb_synaptic_update_ctrl.sv
// Directed bench for synaptic_update_ctrl with 3 pre neurons, 8 post neurons, 4 per word.
// Expected per-cycle vectors are written out by hand from the address mapping.
module tb_synaptic_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        HOLD = 1'b0;
  logic        IS_TRAIN = 1'b0;
  logic        BUSY, DONE;
  logic        SCS, SWE, GCS, GWE, TREF;
  logic [15:0] ADDR;
  logic [9:0]  PRE, POST;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_since = 0;
  int done_cyc = 0;
  int tref_cnt = 0;

  always #5 CLK = ~CLK;

  synaptic_update_ctrl #(
    .INPUT_NEURON(3), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(4),
    .PRE_NEUR_ADDR_WIDTH(10), .POST_NEUR_ADDR_WIDTH(10), .SYN_ARRAY_ADDR_WIDTH(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .HOLD(HOLD),
    .IS_TRAIN(IS_TRAIN), .BUSY(BUSY), .DONE(DONE),
    .CTRL_SYNARRAY_CS(SCS), .CTRL_SYNARRAY_WE(SWE), .CTRL_SYNARRAY_ADDR(ADDR),
    .CTRL_GRAD_ARRAY_CS(GCS), .CTRL_GRAD_ARRAY_WE(GWE),
    .CTRL_PRE_NEURON_ADDRESS(PRE), .CTRL_POST_NEURON_ADDRESS(POST),
    .CTRL_TREF_EVENT(TREF)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {21'd0, BUSY, DONE, SCS, GCS, SWE, GWE, TREF, ADDR, PRE, POST};
  endfunction

  function automatic logic [63:0] strobes();
    return {57'd0, BUSY, DONE, SCS, GCS, SWE, GWE, TREF};
  endfunction

  function automatic logic [63:0] ev(input bit busy, input bit done, input bit cs,
                                     input bit we, input int addr, input int pre, input int post);
    return {21'd0, busy, done, cs, cs, we, we, we, 16'(addr), 10'(pre), 10'(post)};
  endfunction

  // Undisturbed sweep, cycle idx counted from 1 after the START edge:
  // words 0..5 each take RD then WR, FIN at 13, IDLE from 14.
  // Word a maps to pre=a/2 and post base (a%2)*4 since there are 2 words per pre neuron.
  function automatic logic [63:0] exp_norm(input int idx);
    int a;
    if (idx <= 12) begin
      a = (idx - 1) / 2;
      return ev(1'b1, 1'b0, 1'b1, 1'((idx - 1) % 2), a, a / 2, (a % 2) * 4);
    end else if (idx == 13) begin
      return ev(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    end
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
    cyc_since++;
    if (DONE && done_cyc == 0) done_cyc = cyc_since;
    if (TREF) tref_cnt++;
  endtask

  task automatic start_sweep();
    START = 1'b1;
    IS_TRAIN = 1'b1;
    cyc_since = 0;
    done_cyc = 0;
    tref_cnt = 0;
    cyc();
    START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then START already high when reset releases mid-cycle.
    repeat (2) @(posedge CLK);
    #3;
    check_eq("reset_state", obs(), 64'd0);
    START = 1'b1;
    IS_TRAIN = 1'b1;
    cyc_since = 0;
    done_cyc = 0;
    tref_cnt = 0;
    RST_N = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check_eq($sformatf("norm_c%0d", k), obs(), exp_norm(k));
      if (k < 14) cyc();
    end
    check_eq("norm_done_cycle", 64'(done_cyc), 64'd13);
    check_eq("norm_tref_count", 64'(tref_cnt), 64'd6);
    $display("[TB] txn normal sweep done_cyc=%0d tref=%0d", done_cyc, tref_cnt);

    // HOLD for three edges while reading word 2.
    start_sweep();
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("hold_pre_c%0d", k), obs(), exp_norm(k));
      cyc();
    end
    check_eq("hold_rd2", obs(), exp_norm(5));
    HOLD = 1'b1;
    for (int h = 0; h < 3; h++) begin
      cyc();
      check_eq($sformatf("hold_stall%0d", h), obs(), ev(1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 0));
    end
    HOLD = 1'b0;
    for (int k = 6; k <= 14; k++) begin
      cyc();
      check_eq($sformatf("hold_post_c%0d", k), obs(), exp_norm(k));
    end
    check_eq("hold_done_cycle", 64'(done_cyc), 64'd16);
    check_eq("hold_tref_count", 64'(tref_cnt), 64'd6);
    $display("[TB] txn hold sweep done_cyc=%0d tref=%0d", done_cyc, tref_cnt);

    // ABORT while reading word 3: three writes happened, no write to word 3.
    start_sweep();
    for (int k = 1; k <= 6; k++) cyc();
    check_eq("abrd_rd3", obs(), exp_norm(7));
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    check_eq("abrd_idle", strobes(), 64'd0);
    repeat (20) cyc();
    check_eq("abrd_tref_count", 64'(tref_cnt), 64'd3);
    check_eq("abrd_no_done", 64'(done_cyc), 64'd0);
    $display("[TB] txn abort in RD tref=%0d done_cyc=%0d", tref_cnt, done_cyc);

    // ABORT during the write of word 3: that write completes, then idle.
    start_sweep();
    for (int k = 1; k <= 7; k++) cyc();
    check_eq("abwr_wr3", obs(), exp_norm(8));
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    check_eq("abwr_idle", strobes(), 64'd0);
    repeat (20) cyc();
    check_eq("abwr_tref_count", 64'(tref_cnt), 64'd4);
    check_eq("abwr_no_done", 64'(done_cyc), 64'd0);
    $display("[TB] txn abort in WR tref=%0d done_cyc=%0d", tref_cnt, done_cyc);

    // START without IS_TRAIN is ignored.
    START = 1'b1;
    IS_TRAIN = 1'b0;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("notrain_c%0d", k), strobes(), 64'd0);
      cyc();
    end
    $display("[TB] txn start without train ignored");

    // Second START at word 1 during a sweep is ignored.
    start_sweep();
    for (int k = 1; k <= 14; k++) begin
      check_eq($sformatf("restart_c%0d", k), obs(), exp_norm(k));
      START = (k == 3);
      if (k < 14) cyc();
    end
    START = 1'b0;
    check_eq("restart_done_cycle", 64'(done_cyc), 64'd13);
    check_eq("restart_tref_count", 64'(tref_cnt), 64'd6);
    $display("[TB] txn restart ignored done_cyc=%0d", done_cyc);

    // Asynchronous reset during the write of word 4.
    start_sweep();
    for (int k = 1; k <= 9; k++) cyc();
    check_eq("rst_wr4", obs(), exp_norm(10));
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("rst_async_zero", obs(), 64'd0);
    cyc();
    #2;
    RST_N = 1'b1;
    done_cyc = 0;
    repeat (5) cyc();
    check_eq("rst_idle", obs(), 64'd0);
    check_eq("rst_no_done", 64'(done_cyc), 64'd0);
    start_sweep();
    for (int k = 1; k <= 14; k++) begin
      check_eq($sformatf("rst_new_c%0d", k), obs(), exp_norm(k));
      if (k < 14) cyc();
    end
    check_eq("rst_new_done_cycle", 64'(done_cyc), 64'd13);
    $display("[TB] txn reset mid-sweep then new sweep done_cyc=%0d", done_cyc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/synaptic_update_ctrl.md
SYNAPTIC_UPDATE_CTRL -- requirements
Module: synaptic_update_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- INPUT_NEURON, 784: pre-neuron count.
- OUTPUT_NEURON, 256: post-neuron count.
- POST_NEUR_PARALLEL, 4: post neurons per synaptic word.
- PRE_NEUR_ADDR_WIDTH, 10: pre-neuron address width.
- POST_NEUR_ADDR_WIDTH, 10: post-neuron address width.
- SYN_ARRAY_ADDR_WIDTH, 16: synaptic and gradient array address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1: single clock, rising edge.
- RST_N, in, 1: reset; asynchronous, active-low.
- START, in, 1: sweep request pulse.
- ABORT, in, 1: cancel sweep.
- HOLD, in, 1: stall before the next read.
- IS_TRAIN, in, 1: training enable.
- BUSY, out, 1: sweep in progress.
- DONE, out, 1: one-cycle completion pulse.
- CTRL_SYNARRAY_CS, out, 1: synaptic array chip select.
- CTRL_SYNARRAY_WE, out, 1: synaptic array write enable.
- CTRL_SYNARRAY_ADDR, out, SYN_ARRAY_ADDR_WIDTH: word address; shared by both arrays.
- CTRL_GRAD_ARRAY_CS, out, 1: gradient array chip select.
- CTRL_GRAD_ARRAY_WE, out, 1: gradient array write enable.
- CTRL_PRE_NEURON_ADDRESS, out, PRE_NEUR_ADDR_WIDTH: pre-neuron spike-count read address.
- CTRL_POST_NEURON_ADDRESS, out, POST_NEUR_ADDR_WIDTH: first post neuron of the current word.
- CTRL_TREF_EVENT, out, 1: update-commit strobe to the weight/gradient update units.

Function
REQ-003 POST_WORDS SHALL equal OUTPUT_NEURON/POST_NEUR_PARALLEL.
REQ-004 Word address SHALL equal pre*POST_WORDS + w, where pre is in 0..INPUT_NEURON-1 and w is in 0..POST_WORDS-1.
REQ-005 CTRL_POST_NEURON_ADDRESS SHALL equal w*POST_NEUR_PARALLEL.
REQ-006 CTRL_PRE_NEURON_ADDRESS SHALL equal pre.
REQ-007 The FSM SHALL have exactly four states: IDLE, RD, WR, FIN.
REQ-008 IDLE: when START=1 and IS_TRAIN=1, the FSM SHALL load pre=0, w=0 and go to RD; START with IS_TRAIN=0 SHALL be ignored.
REQ-009 RD outputs: SYNARRAY_CS=1, GRAD_ARRAY_CS=1, both WE=0, TREF_EVENT=0. With HOLD=0 the next state SHALL be WR; with HOLD=1 the FSM SHALL stay in RD with the address unchanged and both CS=0.
REQ-010 WR outputs: same address as the preceding RD, both CS=1, both WE=1, TREF_EVENT=1. HOLD SHALL be ignored in WR.
REQ-011 WR advance: w increments; on w=POST_WORDS-1, w wraps to 0 and pre increments. If pre=INPUT_NEURON-1 and w=POST_WORDS-1, the next state SHALL be FIN; otherwise RD.
REQ-012 FIN SHALL assert DONE=1 for exactly one cycle, then go to IDLE.
REQ-013 BUSY SHALL be 1 in RD, WR and FIN, and 0 in IDLE.
REQ-014 START while BUSY=1 SHALL be ignored.
REQ-015 ABORT SHALL be taken in RD: go to IDLE next cycle, no DONE, no further writes.
REQ-016 ABORT in WR SHALL let the write complete and then go to IDLE.
REQ-017 ABORT SHALL have priority over HOLD.
REQ-018 In IDLE and FIN, all CS, WE and TREF_EVENT SHALL be 0.
REQ-019 Address outputs SHALL be registered, and strobes SHALL be decoded from the registered state only (no input-to-output combinational path).
REQ-020 With HOLD=0, the cycles from the START edge to DONE SHALL be 2*INPUT_NEURON*POST_WORDS+1.
REQ-021 Each address SHALL be written exactly once per sweep, in ascending order.

Reset
REQ-022 While RST_N=0: state=IDLE, pre=0, w=0, all outputs 0.
REQ-023 Reset asserted mid-sweep SHALL abandon the sweep immediately (asynchronously); no DONE SHALL follow.
REQ-024 After RST_N deasserts, START SHALL be accepted on the first clock edge.

Structure
REQ-025 Package synaptic_ctrl_pkg SHALL hold the FSM state enum and the POST_WORDS/address-mapping constants.
REQ-026 Sub-module synaptic_addr_gen SHALL hold the nested pre/w counters (clear, advance, last flag, address outputs).
REQ-027 Target size: 120-400 lines of RTL.

Verification
REQ-028 With INPUT_NEURON=3, OUTPUT_NEURON=8, POST_NEUR_PARALLEL=4, HOLD=0: START with IS_TRAIN=1 -> addresses 0..5, each RD then WR; CTRL_POST_NEURON_ADDRESS sequence 0,4,0,4,0,4; DONE 13 cycles after START; 6 TREF_EVENT pulses.
REQ-029 HOLD=1 for 3 cycles while in RD at addr 2 -> CS=0 for those 3 cycles, addr stays 2, then WR to 2; DONE is delayed by exactly 3 cycles.
REQ-030 ABORT in RD at addr 3 -> no WE for addr 3, BUSY=0 next cycle, DONE never asserts. ABORT in WR at addr 3 -> the write to addr 3 completes, then IDLE.
REQ-031 START with IS_TRAIN=0 -> BUSY stays 0 and no CS asserts. START pulsed again at addr 1 mid-sweep -> ignored; the sweep finishes normally.
REQ-032 RST_N=0 asserted during WR at addr 4 -> all outputs 0 immediately; after release, a new START sweeps from addr 0.
REQ-033 Default parameters, HOLD=0 -> final write at addr 50175 with CTRL_PRE_NEURON_ADDRESS=783 and CTRL_POST_NEURON_ADDRESS=252; DONE 100353 cycles after START.
